// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: serves IFU word fetches from a local SRAM
// model with programmable latency and a side-band preload port.
module inst_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
    localparam logic [3:0]  LAT    = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic [31:0]   rd_addr;
    logic [29:0]   rd_woff;
    logic          rd_hit;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    logic [29:0]   ld_woff;
    logic          ld_hit;
    logic [AW-1:0] ld_idx;

    // Zero-latency reads use the live request address at the accept edge
    assign rd_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign rd_woff = rd_addr[31:2] - BASE_W;
    assign rd_hit  = (rd_addr[1:0] == 2'b00) &&
                     (rd_woff[29:AW] == '0);
    assign rd_idx  = rd_woff[AW-1:0];
    assign rd_word = rd_hit ? mem[rd_idx] : 32'h0;

    assign ld_woff = ld_addr[31:2] - BASE_W;
    assign ld_hit  = (ld_addr[1:0] == 2'b00) &&
                     (ld_woff[29:AW] == '0);
    assign ld_idx  = ld_woff[AW-1:0];

    always_ff @(posedge clk) begin
        if (ld_en && ld_hit) begin
            mem[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    cnt_d  = LAT;
                    if (LAT == 4'd0) begin
                        data_d  = rd_word;
                        err_d   = !rd_hit;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    data_d  = rd_word;
                    err_d   = !rd_hit;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: three instances at
// LATENCY 0, 1 and 3 share reset and the preload port.
module tb_inst_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = 32'h0;
    logic [31:0] ld_data = 32'h0;

    logic        rv [3];
    logic        rr [3];
    logic        qr [3];
    logic        sv [3];
    logic [31:0] sd [3];
    logic        se [3];

    int lat [3] = '{0, 1, 3};
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inst_mem_responder #(.LATENCY(0)) u_l0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[0]), .req_ready(qr[0]),
        .req_addr(req_addr),
        .rsp_valid(sv[0]), .rsp_ready(rr[0]),
        .rsp_data(sd[0]), .rsp_err(se[0]),
        .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    inst_mem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[1]), .req_ready(qr[1]),
        .req_addr(req_addr),
        .rsp_valid(sv[1]), .rsp_ready(rr[1]),
        .rsp_data(sd[1]), .rsp_err(se[1]),
        .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    inst_mem_responder #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv[2]), .req_ready(qr[2]),
        .req_addr(req_addr),
        .rsp_valid(sv[2]), .rsp_ready(rr[2]),
        .rsp_data(sd[2]), .rsp_err(se[2]),
        .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a,
                        input logic [31:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Issues one request and waits for rsp_valid; leaves it pending
    task automatic fetch(input int d, input logic [31:0] a,
                         output int cyc, output logic [31:0] data,
                         output logic err, output logic rlow);
        req_addr = a;
        rv[d] = 1'b1;
        tick();
        rv[d] = 1'b0;
        cyc = 0;
        rlow = 1'b1;
        while (sv[d] !== 1'b1 && cyc < 40) begin
            if (qr[d] !== 1'b0) rlow = 1'b0;
            tick();
            cyc++;
        end
        if (qr[d] !== 1'b0) rlow = 1'b0;
        data = sd[d];
        err = se[d];
    endtask

    task automatic ack(input int d);
        rr[d] = 1'b1;
        tick();
        rr[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            n_chk += 4;
            if (qr[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_req_ready[%0d] got %b want 1",
                         d, qr[d]);
            end
            if (sv[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rsp_valid[%0d] got %b want 0",
                         d, sv[d]);
            end
            if (sd[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rsp_data[%0d] got %h want 0",
                         d, sd[d]);
            end
            if (se[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rsp_err[%0d] got %b want 0",
                         d, se[d]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch_basic();
        int c;
        logic [31:0] dat;
        logic e, rl;
        fetch(1, 32'h8000_0000, c, dat, e, rl);
        n_chk += 4;
        if (c !== 1) begin
            n_fail++;
            $display("FAIL basic0_latency got %0d want 1", c);
        end
        if (dat !== 32'h00F0_0093) begin
            n_fail++;
            $display("FAIL basic0_data got %h want 00f00093", dat);
        end
        if (e !== 1'b0) begin
            n_fail++;
            $display("FAIL basic0_err got %b want 0", e);
        end
        if (rl !== 1'b1) begin
            n_fail++;
            $display("FAIL basic0_ready_low got %b want 1", rl);
        end
        ack(1);
        n_chk += 2;
        if (sv[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic0_valid_drop got %b want 0", sv[1]);
        end
        if (qr[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic0_ready_back got %b want 1", qr[1]);
        end
        fetch(1, 32'h8000_0004, c, dat, e, rl);
        n_chk += 2;
        if (dat !== 32'h00F0_0193) begin
            n_fail++;
            $display("FAIL basic1_data got %h want 00f00193", dat);
        end
        if (e !== 1'b0) begin
            n_fail++;
            $display("FAIL basic1_err got %b want 0", e);
        end
        ack(1);
    endtask

    task automatic test_latency();
        int c;
        logic [31:0] dat;
        logic e, rl;
        for (int d = 0; d < 3; d += 2) begin
            fetch(d, 32'h8000_0004, c, dat, e, rl);
            n_chk += 3;
            if (c !== lat[d]) begin
                n_fail++;
                $display("FAIL latency[%0d] got %0d want %0d",
                         d, c, lat[d]);
            end
            if (dat !== 32'h00F0_0193) begin
                n_fail++;
                $display("FAIL lat_data[%0d] got %h want 00f00193",
                         d, dat);
            end
            if (rl !== 1'b1) begin
                n_fail++;
                $display("FAIL lat_ready_low[%0d] got %b want 1",
                         d, rl);
            end
            ack(d);
        end
    endtask

    task automatic test_backpressure();
        int c;
        logic [31:0] dat;
        logic e, rl;
        fetch(2, 32'h8000_0000, c, dat, e, rl);
        for (int i = 0; i < 5; i++) begin
            req_addr = 32'h8000_0004;
            rv[2] = 1'b1;
            tick();
            n_chk += 3;
            if (sv[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_valid[%0d] got %b want 1",
                         i, sv[2]);
            end
            if (sd[2] !== 32'h00F0_0093) begin
                n_fail++;
                $display("FAIL bp_data[%0d] got %h want 00f00093",
                         i, sd[2]);
            end
            if (qr[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready[%0d] got %b want 0",
                         i, qr[2]);
            end
        end
        rv[2] = 1'b0;
        ack(2);
        n_chk += 2;
        if (sv[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_valid_drop got %b want 0", sv[2]);
        end
        if (qr[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_back got %b want 1", qr[2]);
        end
    endtask

    task automatic test_faults();
        logic [31:0] fa [5];
        logic [31:0] fd [5];
        logic        fe [5];
        int c;
        logic [31:0] dat;
        logic e, rl;
        fa = '{32'h8000_0002, 32'h8000_1000, 32'h7FFF_FFFC,
               32'h8000_0FFC, 32'h8000_0000};
        fd = '{32'h0, 32'h0, 32'h0,
               32'hCAFE_F00D, 32'h00F0_0093};
        fe = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        load(32'h8000_1000, 32'h0000_0BAD);
        load(32'h8000_0001, 32'h0000_0BAD);
        for (int i = 0; i < 5; i++) begin
            fetch(1, fa[i], c, dat, e, rl);
            n_chk += 2;
            if (e !== fe[i]) begin
                n_fail++;
                $display("FAIL fault_err %h got %b want %b",
                         fa[i], e, fe[i]);
            end
            if (dat !== fd[i]) begin
                n_fail++;
                $display("FAIL fault_data %h got %h want %h",
                         fa[i], dat, fd[i]);
            end
            ack(1);
        end
    endtask

    task automatic test_rbw();
        int c;
        logic [31:0] dat;
        logic e, rl;
        req_addr = 32'h8000_0008;
        rv[1] = 1'b1;
        tick();
        rv[1] = 1'b0;
        ld_en = 1'b1;
        ld_addr = 32'h8000_0008;
        ld_data = 32'hDEAD_BEEF;
        tick();
        ld_en = 1'b0;
        n_chk += 2;
        if (sv[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rbw1_valid got %b want 1", sv[1]);
        end
        if (sd[1] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL rbw1_old got %h want 12345678", sd[1]);
        end
        ack(1);
        fetch(1, 32'h8000_0008, c, dat, e, rl);
        n_chk++;
        if (dat !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rbw1_new got %h want deadbeef", dat);
        end
        ack(1);
        req_addr = 32'h8000_000C;
        rv[0] = 1'b1;
        ld_en = 1'b1;
        ld_addr = 32'h8000_000C;
        ld_data = 32'h1111_1111;
        tick();
        rv[0] = 1'b0;
        ld_en = 1'b0;
        n_chk += 2;
        if (sv[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rbw0_valid got %b want 1", sv[0]);
        end
        if (sd[0] !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL rbw0_old got %h want 00000013", sd[0]);
        end
        ack(0);
        fetch(0, 32'h8000_000C, c, dat, e, rl);
        n_chk++;
        if (dat !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL rbw0_new got %h want 11111111", dat);
        end
        ack(0);
    endtask

    task automatic test_reset_mid();
        int c;
        logic [31:0] dat;
        logic e, rl;
        req_addr = 32'h8000_0004;
        rv[2] = 1'b1;
        tick();
        rv[2] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        n_chk += 2;
        if (sv[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_valid got %b want 0", sv[2]);
        end
        if (qr[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_ready got %b want 1", qr[2]);
        end
        rst_n = 1'b1;
        rl = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sv[2] !== 1'b0) rl = 1'b1;
        end
        n_chk++;
        if (rl !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_stale got %b want 0", rl);
        end
        fetch(2, 32'h8000_0000, c, dat, e, rl);
        n_chk += 2;
        if (c !== 3) begin
            n_fail++;
            $display("FAIL rstmid_latency got %0d want 3", c);
        end
        if (dat !== 32'h00F0_0093) begin
            n_fail++;
            $display("FAIL rstmid_mem got %h want 00f00093", dat);
        end
        ack(2);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rv[d] = 1'b0;
            rr[d] = 1'b0;
        end
        test_reset();
        load(32'h8000_0000, 32'h00F0_0093);
        load(32'h8000_0004, 32'h00F0_0193);
        load(32'h8000_0008, 32'h1234_5678);
        load(32'h8000_000C, 32'h0000_0013);
        load(32'h8000_0FFC, 32'hCAFE_F00D);
        test_fetch_basic();
        test_latency();
        test_backpressure();
        test_faults();
        test_rbw();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
